// File: rtl/key_pkg.sv
// Shared types and helpers for the key_reader block: per-key FSM state
// encoding, hold-counter width and the tick divider width calculation.
package key_pkg;

  // Per-key classifier states, fixed 3-bit encoding
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PRESS_DB = 3'd1,
    HELD     = 3'd2,
    LONG     = 3'd3,
    REL_DB   = 3'd4
  } key_state_t;

  // Width of the per-key millisecond hold counter (saturates at 4095)
  localparam int MS_CNT_W = 12;

  // Width of the shared 1 ms divider; never below 1 bit so tiny clocks still build
  function automatic int tick_cnt_width(input int clk_hz);
    int div;
    div = clk_hz / 1000;
    return (div <= 2) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/key_reader_if.sv
// Key pin / event bundle between the board pins, key_reader and the
// application. The slave side is key_reader itself; the master side is
// whatever drives the pins and consumes the events.
interface key_reader_if #(
  parameter int N_KEYS = 3
);

  logic [N_KEYS-1:0] key_n;
  logic [N_KEYS-1:0] key_level;
  logic [N_KEYS-1:0] key_press;
  logic [N_KEYS-1:0] key_release;
  logic [N_KEYS-1:0] key_long;
  logic              tick_1ms;

  modport master (
    output key_n,
    input  key_level, key_press, key_release, key_long, tick_1ms
  );

  modport slave (
    input  key_n,
    output key_level, key_press, key_release, key_long, tick_1ms
  );

endinterface

// File: rtl/key_fsm.sv
// One key: 2-FF synchroniser, tick-quantised debounce and press / release /
// long-press classification. Optional macro KEY_READER_AUTOREPEAT_EN adds
// periodic key_long repeats while the key stays in LONG.
module key_fsm
  import key_pkg::*;
#(
  parameter int DEBOUNCE_MS = 20,
  parameter int LONG_MS     = 1000
`ifdef KEY_READER_AUTOREPEAT_EN
  ,
  parameter int REPEAT_MS   = 200
`endif
) (
  input  logic clk,
  input  logic res,
  input  logic tick_1ms,
  input  logic key_n,
  output logic key_level,
  output logic key_press,
  output logic key_release,
  output logic key_long
);

  localparam logic [7:0]          DB_LAST   = 8'(DEBOUNCE_MS - 1);
  localparam logic [MS_CNT_W-1:0] HOLD_LAST = MS_CNT_W'(LONG_MS - DEBOUNCE_MS - 1);
`ifdef KEY_READER_AUTOREPEAT_EN
  localparam logic [MS_CNT_W-1:0] REP_LAST  = MS_CNT_W'(REPEAT_MS - 1);
`endif

  logic                sync_q1, sync_q2;
  logic                p;
  key_state_t          state_q, state_d;
  logic [7:0]          db_cnt_q, db_cnt_d;
  logic [MS_CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [MS_CNT_W-1:0] hold_inc;
  logic                from_long_q, from_long_d;
  logic                db_done;
  logic                hold_done;
  logic                rep_done;

  assign p         = ~sync_q2;
  assign db_done   = tick_1ms && (db_cnt_q == DB_LAST);
  assign hold_done = tick_1ms && (hold_cnt_q == HOLD_LAST);
  assign hold_inc  = (hold_cnt_q == '1) ? hold_cnt_q : hold_cnt_q + 1'b1;
`ifdef KEY_READER_AUTOREPEAT_EN
  assign rep_done  = tick_1ms && (hold_cnt_q == REP_LAST);
`else
  assign rep_done  = 1'b0;
`endif

  // Bring the raw pin into the clock domain; preset to released so a key
  // held through reset is seen as a fresh press
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      sync_q1 <= 1'b1;
      sync_q2 <= 1'b1;
    end else begin
      sync_q1 <= key_n;
      sync_q2 <= sync_q1;
    end
  end

  // State, counters and the "came from LONG" flag
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state_q     <= IDLE;
      db_cnt_q    <= '0;
      hold_cnt_q  <= '0;
      from_long_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      db_cnt_q    <= db_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      from_long_q <= from_long_d;
    end
  end

  // Next-state logic; the hold counter is frozen in REL_DB so a release
  // bounce resumes the hold (and the repeat phase) where it left off
  always_comb begin
    state_d     = state_q;
    db_cnt_d    = db_cnt_q;
    hold_cnt_d  = hold_cnt_q;
    from_long_d = from_long_q;
    case (state_q)
      IDLE: begin
        if (p) begin
          state_d  = PRESS_DB;
          db_cnt_d = '0;
        end
      end
      PRESS_DB: begin
        if (!p) begin
          state_d = IDLE;
        end else if (db_done) begin
          state_d     = HELD;
          hold_cnt_d  = '0;
          from_long_d = 1'b0;
        end else if (tick_1ms) begin
          db_cnt_d = db_cnt_q + 1'b1;
        end
      end
      HELD: begin
        if (!p) begin
          state_d  = REL_DB;
          db_cnt_d = '0;
        end else if (hold_done) begin
          state_d     = LONG;
          hold_cnt_d  = '0;
          from_long_d = 1'b1;
        end else if (tick_1ms) begin
          hold_cnt_d = hold_inc;
        end
      end
      LONG: begin
        if (!p) begin
          state_d  = REL_DB;
          db_cnt_d = '0;
        end else if (rep_done) begin
          hold_cnt_d = '0;
`ifdef KEY_READER_AUTOREPEAT_EN
        end else if (tick_1ms) begin
          hold_cnt_d = hold_inc;
`endif
        end
      end
      REL_DB: begin
        if (p) begin
          state_d = from_long_q ? LONG : HELD;
        end else if (db_done) begin
          state_d = IDLE;
        end else if (tick_1ms) begin
          db_cnt_d = db_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Event pulses fire in the cycle the qualifying transition is taken
  always_comb begin
    key_level   = (state_q == HELD) || (state_q == LONG) || (state_q == REL_DB);
    key_press   = (state_q == PRESS_DB) && p && db_done;
    key_release = (state_q == REL_DB) && !p && db_done;
    key_long    = ((state_q == HELD) && p && hold_done) ||
                  ((state_q == LONG) && p && rep_done);
  end

endmodule

// File: rtl/key_reader.sv
// Push-button / switch conditioner: shared 1 ms tick divider plus one
// key_fsm per key. Optional macro KEY_READER_AUTOREPEAT_EN enables key_long
// auto-repeat every REPEAT_MS while a key stays held.
module key_reader
  import key_pkg::*;
#(
  parameter int CLK_HZ      = 48000000,
  parameter int N_KEYS      = 3,
  parameter int DEBOUNCE_MS = 20,
  parameter int LONG_MS     = 1000,
  parameter int REPEAT_MS   = 200
) (
  input logic         clk,
  input logic         res,
  key_reader_if.slave bus
);

  localparam int               TICK_W    = tick_cnt_width(CLK_HZ);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CLK_HZ / 1000 - 1);

  logic [TICK_W-1:0] tick_cnt;
  logic              tick;
  logic [N_KEYS-1:0] level_v, press_v, release_v, long_v;

  // Catch out-of-range timing parameters at elaboration
  if (DEBOUNCE_MS < 1 || DEBOUNCE_MS > 255 || LONG_MS <= DEBOUNCE_MS ||
      LONG_MS > 4095 || REPEAT_MS < 1 || REPEAT_MS > 4095 || CLK_HZ < 1000) begin : g_bad_cfg
    $error("key_reader: timing parameters out of range");
  end

  assign tick = (tick_cnt == TICK_LAST);

  // Free-running 1 ms divider shared by all keys
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  for (genvar k = 0; k < N_KEYS; k++) begin : g_key
    key_fsm #(
      .DEBOUNCE_MS (DEBOUNCE_MS),
      .LONG_MS     (LONG_MS)
`ifdef KEY_READER_AUTOREPEAT_EN
      ,
      .REPEAT_MS   (REPEAT_MS)
`endif
    ) u_key (
      .clk         (clk),
      .res         (res),
      .tick_1ms    (tick),
      .key_n       (bus.key_n[k]),
      .key_level   (level_v[k]),
      .key_press   (press_v[k]),
      .key_release (release_v[k]),
      .key_long    (long_v[k])
    );
  end

  assign bus.key_level   = level_v;
  assign bus.key_press   = press_v;
  assign bus.key_release = release_v;
  assign bus.key_long    = long_v;
  assign bus.tick_1ms    = tick;

endmodule
